txn_requester: RTL and testbench

- Upstream request stage that drives the `valid` / `tx_*` request input of the inner responder path and consumes its `ready` / `rdata` response.
- On a `start` command it issues `count` single-beat requests, one at a time.
- For each accepted beat it captures the response data, accumulates a running sum, and counts completed beats.
- It guards each beat with a timeout and reports completion or timeout to the controlling logic.

---
 rtl/txn_requester.sv | 194 +++++++++++++++++++
 tb/tb_txn_requester.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txn_requester.sv
// -----------------------------------------------------------------------------
// txn_requester
//
// Upstream request stage. On a `start` command it issues `count` single-beat
// requests to a downstream responder, one at a time. For each accepted beat it
// captures the response, keeps a running sum and counts completed beats. Each
// beat is guarded by a timeout. Completion or abort is reported with a
// one-cycle `done` pulse.
//
// Ports:
//   clock      - block clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   start      - command strobe, sampled only in IDLE
//   count      - number of beats to issue, sampled with `start`
//   tx_valid   - request to downstream (decoded from registered state only)
//   rx_ready   - downstream accept, may depend combinationally on tx_valid
//   rx_rdata   - downstream response data, valid when tx_valid && rx_ready
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse at the end of every command
//   timeout    - sticky abort flag, cleared by the next accepted start
//   last_data  - rx_rdata of the most recent accepted beat
//   sum        - zero-extended running sum of accepted rx_rdata (wraps)
//   xfer_cnt   - beats accepted in the current command
// -----------------------------------------------------------------------------
module txn_requester #(
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 4,
  parameter int SUM_W      = 8,
  parameter int TIMEOUT    = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic              tx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] last_data,
  output logic [SUM_W-1:0]  sum,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Counter widths; a degenerate parameter value still gets a 1-bit counter.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  // Unused when GAP_CYCLES is 0 because the GAP state is then never entered.
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic [WAIT_W-1:0]   wait_q,      wait_d;
  logic [GAP_W-1:0]    gap_q,       gap_d;
  logic                tx_valid_q,  tx_valid_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                timeout_q,   timeout_d;
  logic [DATA_W-1:0]   last_data_q, last_data_d;
  logic [SUM_W-1:0]    sum_q,       sum_d;
  logic [CNT_W-1:0]    xfer_cnt_q,  xfer_cnt_d;

  logic handshake;

  // tx_valid_q is only ever high in REQ, so this is the beat-accept condition.
  assign handshake = tx_valid_q && rx_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d     = state_q;
    count_d     = count_q;
    wait_d      = wait_q;
    gap_d       = gap_q;
    timeout_d   = timeout_q;
    last_data_d = last_data_q;
    sum_d       = sum_q;
    xfer_cnt_d  = xfer_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d      = '0;
          xfer_cnt_d = '0;
          timeout_d  = 1'b0;
          wait_d     = '0;
          gap_d      = '0;
          if (count != '0) begin
            count_d = count;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_REQ: begin
        if (handshake) begin
          last_data_d = rx_rdata;
          sum_d       = sum_q + SUM_W'(rx_rdata);
          xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
          wait_d      = '0;
          if (xfer_cnt_d == count_q) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            state_d = S_REQ;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Request withdrawn only here: the beat waited TIMEOUT cycles.
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_REQ;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they carry no
    // combinational path from any input.
    tx_valid_d = (state_d == S_REQ);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wait_q      <= '0;
      gap_q       <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_data_q <= '0;
      sum_q       <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      gap_q       <= gap_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      last_data_q <= last_data_d;
      sum_q       <= sum_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign last_data = last_data_q;
  assign sum       = sum_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_txn_requester.sv
// -----------------------------------------------------------------------------
// tb_txn_requester
//
// Self-checking bench for txn_requester. Instance dut_a uses GAP_CYCLES=1,
// instance dut_b uses GAP_CYCLES=0. Each command pushes its expected result
// (latency, sum, beat count, last data, timeout flag) into a per-instance
// queue; a monitor pops and compares on every `done` pulse. Per-cycle
// tx_valid patterns are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_txn_requester;

  localparam int DW = 4;
  localparam int CW = 4;
  localparam int SW = 8;
  localparam int TO = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Instance A (GAP_CYCLES = 1)
  logic          start_a;
  logic [CW-1:0] count_a;
  logic          tx_valid_a;
  logic          rx_ready_a;
  logic [DW-1:0] rx_rdata_a;
  logic          busy_a, done_a, timeout_a;
  logic [DW-1:0] last_a;
  logic [SW-1:0] sum_a;
  logic [CW-1:0] xfer_a;
  logic          tie_a;
  logic          force_ready_a;

  // Downstream model: either ready follows valid, or the bench forces it.
  assign rx_ready_a = tie_a ? tx_valid_a : force_ready_a;

  // Instance B (GAP_CYCLES = 0), downstream always ready.
  logic          start_b;
  logic [CW-1:0] count_b;
  logic          tx_valid_b;
  logic          rx_ready_b;
  logic [DW-1:0] rx_rdata_b;
  logic          busy_b, done_b, timeout_b;
  logic [DW-1:0] last_b;
  logic [SW-1:0] sum_b;
  logic [CW-1:0] xfer_b;

  assign rx_ready_b = tx_valid_b;

  txn_requester #(
    .DATA_W(DW), .CNT_W(CW), .SUM_W(SW), .TIMEOUT(TO), .GAP_CYCLES(1)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .count(count_a),
    .tx_valid(tx_valid_a), .rx_ready(rx_ready_a), .rx_rdata(rx_rdata_a),
    .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .last_data(last_a), .sum(sum_a), .xfer_cnt(xfer_a)
  );

  txn_requester #(
    .DATA_W(DW), .CNT_W(CW), .SUM_W(SW), .TIMEOUT(TO), .GAP_CYCLES(0)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .count(count_b),
    .tx_valid(tx_valid_b), .rx_ready(rx_ready_b), .rx_rdata(rx_rdata_b),
    .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .last_data(last_b), .sum(sum_b), .xfer_cnt(xfer_b)
  );

  typedef struct {
    int            start_cyc;
    int            lat;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    logic [DW-1:0] last;
    logic          to;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one command; cycle k after the start edge sees cyc == start_cyc + k.
  task automatic issue(input bit sel_b, input logic [CW-1:0] c, input int lat,
                       input logic [SW-1:0] s, input logic [CW-1:0] n,
                       input logic [DW-1:0] last, input logic to,
                       input bit push);
    exp_t e;
    @(negedge clock);
    if (sel_b) begin start_b = 1'b1; count_b = c; end
    else       begin start_a = 1'b1; count_a = c; end
    e.start_cyc = cyc;
    e.lat       = lat;
    e.sum       = s;
    e.cnt       = n;
    e.last      = last;
    e.to        = to;
    if (push) begin
      if (sel_b) sb_b.push_back(e);
      else       sb_a.push_back(e);
    end
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input bit sel_b);
    for (int i = 0; i < 40; i++) begin
      if ((sel_b ? sb_b.size() : sb_a.size()) == 0) break;
      @(negedge clock);
    end
    check(sel_b ? "b_drain" : "a_drain", sel_b ? sb_b.size() : sb_a.size(), 0);
  endtask

  // Scoreboard monitors: every done pulse must match the oldest command.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done_a) begin
      if (sb_a.size() == 0) begin
        check("a_done_unexp", done_a, 1'b0);
      end else begin
        e = sb_a.pop_front();
        check("a_latency", cyc - e.start_cyc, e.lat);
        check("a_sum",     sum_a,     e.sum);
        check("a_xfer",    xfer_a,    e.cnt);
        check("a_last",    last_a,    e.last);
        check("a_timeout", timeout_a, e.to);
        check("a_txv_done", tx_valid_a, 1'b0);
        check("a_busy_done", busy_a, 1'b1);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && done_b) begin
      if (sb_b.size() == 0) begin
        check("b_done_unexp", done_b, 1'b0);
      end else begin
        e = sb_b.pop_front();
        check("b_latency", cyc - e.start_cyc, e.lat);
        check("b_sum",     sum_b,     e.sum);
        check("b_xfer",    xfer_b,    e.cnt);
        check("b_last",    last_b,    e.last);
        check("b_timeout", timeout_b, e.to);
      end
    end
  end

  task automatic check_a_zero(input string pfx);
    check({pfx, "_txv"},  tx_valid_a, 1'b0);
    check({pfx, "_busy"}, busy_a,     1'b0);
    check({pfx, "_done"}, done_a,     1'b0);
    check({pfx, "_to"},   timeout_a,  1'b0);
    check({pfx, "_last"}, last_a,     '0);
    check({pfx, "_sum"},  sum_a,      '0);
    check({pfx, "_xfer"}, xfer_a,     '0);
  endtask

  initial begin
    reset         = 1'b1;
    start_a       = 1'b0;
    count_a       = '0;
    rx_rdata_a    = '0;
    tie_a         = 1'b1;
    force_ready_a = 1'b0;
    start_b       = 1'b0;
    count_b       = '0;
    rx_rdata_b    = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_a_zero("rst");
    check("rst_b_txv", tx_valid_b, 1'b0);
    check("rst_b_busy", busy_b, 1'b0);
    reset = 1'b0;

    // Normal run, GAP=1: valid at cycles 1,3,5, done at 6, sum 15.
    rx_rdata_a = 4'h5;
    issue(1'b0, 4'd3, 6, 8'd15, 4'd3, 4'h5, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check("norm_txv", tx_valid_a, (k == 1 || k == 3 || k == 5));
    end
    drain(1'b0);
    repeat (2) @(negedge clock);
    check("hold_sum",  sum_a,  8'd15);
    check("hold_xfer", xfer_a, 4'd3);
    check("hold_busy", busy_a, 1'b0);

    // Back-to-back, GAP=0: valid cycles 1-4, done at 5, sum 60.
    rx_rdata_b = 4'hF;
    issue(1'b1, 4'd4, 5, 8'd60, 4'd4, 4'hF, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check("b2b_txv", tx_valid_b, (k <= 4));
    end
    drain(1'b1);

    // Timeout: ready held low, valid cycles 1-8, done+timeout at 9.
    tie_a         = 1'b0;
    force_ready_a = 1'b0;
    issue(1'b0, 4'd2, 9, 8'd0, 4'd0, 4'h5, 1'b1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      check("to_txv", tx_valid_a, (k <= 8));
    end
    drain(1'b0);
    @(negedge clock);
    check("to_sticky", timeout_a, 1'b1);

    // Late ready on the 8th REQ cycle: accepted, no timeout, done at 9.
    issue(1'b0, 4'd1, 9, 8'd10, 4'd1, 4'hA, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check("late_txv", tx_valid_a, 1'b1);
      if (k == 1) check("to_cleared", timeout_a, 1'b0);
      if (k == 8) begin
        rx_rdata_a    = 4'hA;
        force_ready_a = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    force_ready_a = 1'b0;
    drain(1'b0);

    // Zero count: done at cycle 1, no request.
    tie_a = 1'b1;
    issue(1'b0, 4'd0, 1, 8'd0, 4'd0, 4'hA, 1'b0, 1'b1);
    @(negedge clock);
    check("zero_txv", tx_valid_a, 1'b0);
    drain(1'b0);

    // count=3 with a start while busy that must be ignored.
    rx_rdata_a = 4'h3;
    issue(1'b0, 4'd3, 6, 8'd9, 4'd3, 4'h3, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check("busy_txv", tx_valid_a, (k == 1 || k == 3 || k == 5));
      if (k == 2) begin
        start_a = 1'b1;
        count_a = 4'd1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
      end
    end
    drain(1'b0);
    repeat (10) @(negedge clock);
    check("ign_xfer", xfer_a, 4'd3);
    check("ign_busy", busy_a, 1'b0);

    // Reset during the second REQ of a count=3 run.
    rx_rdata_a = 4'h5;
    issue(1'b0, 4'd3, 0, 8'd0, 4'd0, 4'h0, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("mid_txv", tx_valid_a, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_a_zero("mid_rst");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("mid_no_done", done_a, 1'b0);
    end

    // Clean run after reset: REQ, GAP, REQ, DONE at cycle 4.
    rx_rdata_a = 4'h7;
    issue(1'b0, 4'd2, 4, 8'd14, 4'd2, 4'h7, 1'b0, 1'b1);
    drain(1'b0);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
